// File: rtl/uart_tx_feeder.sv
// UART transmit feeder: byte FIFO plus an issue FSM that hands one byte per frame to the transmitter.
// Optional almost_full output is enabled with `define UART_TX_FEEDER_ALMOST_FULL_EN.
module uart_tx_feeder #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int ALMOST_FULL_LVL = 12,
  parameter int BUSY_TIMEOUT    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          data_valid,
  output logic [DATA_WIDTH-1:0]         parallel_data,
  input  logic                          busy,
  output logic                          tx_error
`ifdef UART_TX_FEEDER_ALMOST_FULL_EN
  ,
  output logic                          almost_full
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_feeder: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (BUSY_TIMEOUT < 2) begin : g_bad_timeout
    $error("uart_tx_feeder: BUSY_TIMEOUT must be >= 2");
  end
  if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > FIFO_DEPTH) begin : g_bad_af_lvl
    $error("uart_tx_feeder: ALMOST_FULL_LVL must be in 1..FIFO_DEPTH");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [TW-1:0]         timer;
  logic                  push, pop, timed_out;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign fifo_count = count;
  assign timed_out  = (timer == TW'(BUSY_TIMEOUT));

  // A pop frees a slot in the same cycle, so a write on a full FIFO is still taken.
  assign pop  = (state == IDLE) && !empty && !busy;
  assign push = wr_en && (!full || pop);

`ifdef UART_TX_FEEDER_ALMOST_FULL_EN
  assign almost_full = (count >= CW'(ALMOST_FULL_LVL));
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      parallel_data <= '0;
      timer         <= '0;
    end else begin
      state    <= state_nxt;
      overflow <= wr_en && full && !pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        parallel_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Cleared while in ISSUE so WAIT_BUSY starts from zero; saturates at the limit.
      if (state == ISSUE)                        timer <= '0;
      else if (state == WAIT_BUSY && !timed_out) timer <= timer + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    data_valid = 1'b0;
    tx_error   = 1'b0;
    case (state)
      IDLE:      if (pop) state_nxt = ISSUE;
      ISSUE: begin
        data_valid = 1'b1;
        state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) state_nxt = WAIT_DONE;
        else if (timed_out) begin
          tx_error  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: if (!busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

endmodule
